uv_bus_arb: RTL and testbench

- Round-robin arbiter that shares one bus slave port among NUM bus masters. Typical slave: the bus-to-APB bridge in front of the peripheral subsystem.
- Allows one outstanding transaction at a time.
- Grants a master, forwards its request, then routes the single response back to that master before re-arbitrating.
- All bus ports use the codebase's bus protocol: req vld/rdy, read, addr, mask, data; rsp vld/rdy, excp, data.

---
 rtl/uv_bus_arb.sv | 183 ++++++++++++++++++
 tb/tb_uv_bus_arb.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uv_bus_arb.sv
// uv_bus_arb: round-robin arbiter sharing one bus slave port among NUM masters.
// One transaction is outstanding at a time: grant, forward the request, route
// the single response back, then re-arbitrate from IDLE.
//
// state   | meaning
// ST_IDLE | no grant held; pick the next requester starting at r_ptr
// ST_REQ  | granted master's request forwarded to the slave until handshake
// ST_RSP  | slave response routed to the granted master until handshake
module uv_bus_arb #(
  parameter int NUM  = 2,
  parameter int ALEN = 12,
  parameter int DLEN = 32,
  parameter int MLEN = DLEN / 8,
  parameter int IDW  = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM-1:0]       mst_req_vld,
  output logic [NUM-1:0]       mst_req_rdy,
  input  logic [NUM-1:0]       mst_req_read,
  input  logic [NUM*ALEN-1:0]  mst_req_addr,
  input  logic [NUM*MLEN-1:0]  mst_req_mask,
  input  logic [NUM*DLEN-1:0]  mst_req_data,
  output logic [NUM-1:0]       mst_rsp_vld,
  input  logic [NUM-1:0]       mst_rsp_rdy,
  output logic [1:0]           mst_rsp_excp,
  output logic [DLEN-1:0]      mst_rsp_data,
  output logic                 slv_req_vld,
  input  logic                 slv_req_rdy,
  output logic                 slv_req_read,
  output logic [ALEN-1:0]      slv_req_addr,
  output logic [MLEN-1:0]      slv_req_mask,
  output logic [DLEN-1:0]      slv_req_data,
  input  logic                 slv_rsp_vld,
  output logic                 slv_rsp_rdy,
  input  logic [1:0]           slv_rsp_excp,
  input  logic [DLEN-1:0]      slv_rsp_data,
  output logic                 arb_busy,
  output logic [IDW-1:0]       arb_gnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [IDW-1:0] r_gnt;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] w_gnt_nxt;
  logic [IDW-1:0] w_ptr_nxt;
  logic [IDW-1:0] w_pick;
  logic           w_any;

  logic            w_sel_vld;
  logic            w_sel_read;
  logic [ALEN-1:0] w_sel_addr;
  logic [MLEN-1:0] w_sel_mask;
  logic [DLEN-1:0] w_sel_data;
  logic            w_sel_rsp_rdy;

  // Round-robin pick: first requester at or above r_ptr, else first below it.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    for (int i = 0; i < NUM; i++) begin
      if (!w_any && mst_req_vld[i] && (IDW'(i) >= r_ptr)) begin
        w_any  = 1'b1;
        w_pick = IDW'(i);
      end
    end
    for (int i = 0; i < NUM; i++) begin
      if (!w_any && mst_req_vld[i] && (IDW'(i) < r_ptr)) begin
        w_any  = 1'b1;
        w_pick = IDW'(i);
      end
    end
  end

  // Select the granted master's request fields and response ready.
  always_comb begin
    w_sel_vld     = 1'b0;
    w_sel_read    = 1'b0;
    w_sel_addr    = '0;
    w_sel_mask    = '0;
    w_sel_data    = '0;
    w_sel_rsp_rdy = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      if (r_gnt == IDW'(i)) begin
        w_sel_vld     = mst_req_vld[i];
        w_sel_read    = mst_req_read[i];
        w_sel_addr    = mst_req_addr[i*ALEN +: ALEN];
        w_sel_mask    = mst_req_mask[i*MLEN +: MLEN];
        w_sel_data    = mst_req_data[i*DLEN +: DLEN];
        w_sel_rsp_rdy = mst_rsp_rdy[i];
      end
    end
  end

  // Next-state, grant and pointer update.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt = ST_REQ;
          w_gnt_nxt   = w_pick;
        end
      end
      ST_REQ: begin
        if (w_sel_vld && slv_req_rdy) begin
          w_state_nxt = ST_RSP;
          w_ptr_nxt   = (r_gnt == IDW'(NUM - 1)) ? '0 : r_gnt + IDW'(1);
        end else if (!w_sel_vld) begin
          // requester withdrew before handshake: drop the grant, keep the pointer
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RSP: begin
        if (slv_rsp_vld && w_sel_rsp_rdy) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, grant and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Bus routing; payloads are zero outside the state that uses them.
  always_comb begin
    mst_req_rdy  = '0;
    mst_rsp_vld  = '0;
    mst_rsp_excp = '0;
    mst_rsp_data = '0;
    slv_req_vld  = 1'b0;
    slv_req_read = 1'b0;
    slv_req_addr = '0;
    slv_req_mask = '0;
    slv_req_data = '0;
    slv_rsp_rdy  = 1'b0;
    case (r_state)
      ST_REQ: begin
        slv_req_vld  = w_sel_vld;
        slv_req_read = w_sel_read;
        slv_req_addr = w_sel_addr;
        slv_req_mask = w_sel_mask;
        slv_req_data = w_sel_data;
        for (int i = 0; i < NUM; i++) begin
          if (r_gnt == IDW'(i)) mst_req_rdy[i] = slv_req_rdy;
        end
      end
      ST_RSP: begin
        slv_rsp_rdy  = w_sel_rsp_rdy;
        mst_rsp_excp = slv_rsp_excp;
        mst_rsp_data = slv_rsp_data;
        for (int i = 0; i < NUM; i++) begin
          if (r_gnt == IDW'(i)) mst_rsp_vld[i] = slv_rsp_vld;
        end
      end
      default: ;
    endcase
  end

  assign arb_busy = (r_state != ST_IDLE);
  assign arb_gnt  = r_gnt;

endmodule

// File: tb/tb_uv_bus_arb.sv
// Bench for uv_bus_arb with three masters: directed scenarios followed by
// randomized traffic, all outputs compared each cycle against a
// transaction-level model of the arbiter.
module tb_uv_bus_arb;

  localparam int NUM  = 3;
  localparam int ALEN = 12;
  localparam int DLEN = 32;
  localparam int MLEN = 4;
  localparam int IDW  = 3;

  logic                clk;
  logic                rst_n;
  logic [NUM-1:0]      mst_req_vld;
  logic [NUM-1:0]      mst_req_rdy;
  logic [NUM-1:0]      mst_req_read;
  logic [NUM*ALEN-1:0] mst_req_addr;
  logic [NUM*MLEN-1:0] mst_req_mask;
  logic [NUM*DLEN-1:0] mst_req_data;
  logic [NUM-1:0]      mst_rsp_vld;
  logic [NUM-1:0]      mst_rsp_rdy;
  logic [1:0]          mst_rsp_excp;
  logic [DLEN-1:0]     mst_rsp_data;
  logic                slv_req_vld;
  logic                slv_req_rdy;
  logic                slv_req_read;
  logic [ALEN-1:0]     slv_req_addr;
  logic [MLEN-1:0]     slv_req_mask;
  logic [DLEN-1:0]     slv_req_data;
  logic                slv_rsp_vld;
  logic                slv_rsp_rdy;
  logic [1:0]          slv_rsp_excp;
  logic [DLEN-1:0]     slv_rsp_data;
  logic                arb_busy;
  logic [IDW-1:0]      arb_gnt;

  uv_bus_arb #(.NUM(NUM), .ALEN(ALEN), .DLEN(DLEN), .MLEN(MLEN), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .mst_req_vld(mst_req_vld), .mst_req_rdy(mst_req_rdy), .mst_req_read(mst_req_read),
    .mst_req_addr(mst_req_addr), .mst_req_mask(mst_req_mask), .mst_req_data(mst_req_data),
    .mst_rsp_vld(mst_rsp_vld), .mst_rsp_rdy(mst_rsp_rdy), .mst_rsp_excp(mst_rsp_excp),
    .mst_rsp_data(mst_rsp_data),
    .slv_req_vld(slv_req_vld), .slv_req_rdy(slv_req_rdy), .slv_req_read(slv_req_read),
    .slv_req_addr(slv_req_addr), .slv_req_mask(slv_req_mask), .slv_req_data(slv_req_data),
    .slv_rsp_vld(slv_rsp_vld), .slv_rsp_rdy(slv_rsp_rdy), .slv_rsp_excp(slv_rsp_excp),
    .slv_rsp_data(slv_rsp_data),
    .arb_busy(arb_busy), .arb_gnt(arb_gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 = waiting to arbitrate, 1 = request outstanding, 2 = response pending.
  int m_phase = 0;
  int m_gnt   = 0;
  int m_ptr   = 0;
  int m_log[$];

  // Requester closest to ptr in circular distance wins.
  function automatic int model_pick(input logic [NUM-1:0] v, input int ptr);
    int best  = -1;
    int bestd = NUM;
    for (int i = 0; i < NUM; i++) begin
      if (v[i]) begin
        int d = (i - ptr + NUM) % NUM;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_gnt   = 0;
      m_ptr   = 0;
    end else begin
      case (m_phase)
        0: if (mst_req_vld != '0) begin
             m_gnt = model_pick(mst_req_vld, m_ptr);
             m_log.push_back(m_gnt);
             m_phase = 1;
           end
        1: if (mst_req_vld[m_gnt] && slv_req_rdy) begin
             m_phase = 2;
             m_ptr   = (m_gnt + 1) % NUM;
           end else if (!mst_req_vld[m_gnt]) begin
             m_phase = 0;
           end
        default: if (slv_rsp_vld && mst_rsp_rdy[m_gnt]) m_phase = 0;
      endcase
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic [NUM-1:0]  e_req_rdy;
    logic [NUM-1:0]  e_rsp_vld;
    logic            e_req_vld;
    logic [63:0]     e_payload;
    logic [63:0]     a_payload;
    e_req_rdy = '0;
    e_rsp_vld = '0;
    e_req_vld = 1'b0;
    e_payload = '0;
    if (m_phase == 1) begin
      e_req_rdy[m_gnt] = slv_req_rdy;
      e_req_vld        = mst_req_vld[m_gnt];
      e_payload = {11'd0, mst_req_read[m_gnt], mst_req_addr[m_gnt*ALEN +: ALEN],
                   mst_req_mask[m_gnt*MLEN +: MLEN], mst_req_data[m_gnt*DLEN +: DLEN]};
    end
    if (m_phase == 2) e_rsp_vld[m_gnt] = slv_rsp_vld;
    a_payload = {11'd0, slv_req_read, slv_req_addr, slv_req_mask, slv_req_data};
    check("cyc_slv_req_vld", 64'(slv_req_vld), 64'(e_req_vld));
    check("cyc_slv_req_payload", a_payload, e_payload);
    check("cyc_mst_req_rdy", 64'(mst_req_rdy), 64'(e_req_rdy));
    check("cyc_mst_rsp_vld", 64'(mst_rsp_vld), 64'(e_rsp_vld));
    check("cyc_slv_rsp_rdy", 64'(slv_rsp_rdy), 64'((m_phase == 2) && mst_rsp_rdy[m_gnt]));
    check("cyc_mst_rsp_excp", 64'(mst_rsp_excp), (m_phase == 2) ? 64'(slv_rsp_excp) : 64'd0);
    check("cyc_mst_rsp_data", 64'(mst_rsp_data), (m_phase == 2) ? 64'(slv_rsp_data) : 64'd0);
    check("cyc_arb_busy", 64'(arb_busy), 64'(m_phase != 0));
    check("cyc_arb_gnt", 64'(arb_gnt), 64'(m_gnt));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    mst_req_vld  = '0;
    mst_req_read = '0;
    mst_req_addr = '0;
    mst_req_mask = '0;
    mst_req_data = '0;
    mst_rsp_rdy  = '0;
    slv_req_rdy  = 1'b0;
    slv_rsp_vld  = 1'b0;
    slv_rsp_excp = '0;
    slv_rsp_data = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (3) tick();
    rst_n = 1'b1;
    m_log.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) tick();
    check("rst_busy", 64'(arb_busy), 64'd0);
    check("rst_gnt", 64'(arb_gnt), 64'd0);
    check("rst_slv_req_vld", 64'(slv_req_vld), 64'd0);
    check("rst_mst_req_rdy", 64'(mst_req_rdy), 64'd0);
    check("rst_slv_req_addr", 64'(slv_req_addr), 64'd0);
    rst_n = 1'b1;
    tick();

    // Single read from master 0.
    mst_req_vld  = 3'b001;
    mst_req_read = 3'b001;
    mst_req_addr[0 +: ALEN] = 12'h010;
    #1;
    check("t1_vld_same_cycle", 64'(slv_req_vld), 64'd0);
    tick();
    check("t1_vld_next_cycle", 64'(slv_req_vld), 64'd1);
    check("t1_addr", 64'(slv_req_addr), 64'h010);
    check("t1_read", 64'(slv_req_read), 64'd1);
    slv_req_rdy = 1'b1;
    tick();
    mst_req_vld  = '0;
    slv_req_rdy  = 1'b0;
    slv_rsp_vld  = 1'b1;
    slv_rsp_data = 32'hDEADBEEF;
    mst_rsp_rdy  = 3'b111;
    #1;
    check("t1_rsp_vld", 64'(mst_rsp_vld), 64'b001);
    check("t1_rsp_data", 64'(mst_rsp_data), 64'hDEADBEEF);
    tick();
    clear_inputs();
    check("t1_idle", 64'(arb_busy), 64'd0);

    // Two masters continuously requesting from reset.
    do_reset();
    mst_req_vld = 3'b011;
    slv_req_rdy = 1'b1;
    slv_rsp_vld = 1'b1;
    mst_rsp_rdy = 3'b111;
    repeat (12) tick();
    clear_inputs();
    check("t2_count", 64'(m_log.size()), 64'd4);
    if (m_log.size() >= 4) begin
      check("t2_gnt0", 64'(m_log[0]), 64'd0);
      check("t2_gnt1", 64'(m_log[1]), 64'd1);
      check("t2_gnt2", 64'(m_log[2]), 64'd0);
      check("t2_gnt3", 64'(m_log[3]), 64'd1);
    end
    tick();

    // Slave stalls request, then master 1 stalls response.
    mst_req_vld = 3'b010;
    mst_req_addr[ALEN +: ALEN] = 12'h0A4;
    mst_req_mask[MLEN +: MLEN] = 4'h3;
    mst_req_data[DLEN +: DLEN] = 32'h12345678;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t3_stall_addr", 64'(slv_req_addr), 64'h0A4);
      check("t3_stall_data", 64'(slv_req_data), 64'h12345678);
      check("t3_stall_rdy", 64'(mst_req_rdy), 64'd0);
      tick();
    end
    slv_req_rdy = 1'b1;
    #1;
    check("t3_hs_rdy", 64'(mst_req_rdy), 64'b010);
    check("t3_hs_mask", 64'(slv_req_mask), 64'h3);
    tick();
    mst_req_vld  = '0;
    slv_req_rdy  = 1'b0;
    slv_rsp_vld  = 1'b1;
    slv_rsp_data = 32'hCAFEF00D;
    mst_rsp_rdy  = 3'b101;
    for (int i = 0; i < 3; i++) begin
      check("t3_rsp_hold", 64'(slv_rsp_rdy), 64'd0);
      tick();
    end
    mst_rsp_rdy = 3'b111;
    #1;
    check("t3_rsp_rdy", 64'(slv_rsp_rdy), 64'd1);
    tick();
    clear_inputs();

    // Write with exception response.
    mst_req_vld = 3'b001;
    mst_req_mask[0 +: MLEN] = 4'hF;
    mst_req_data[0 +: DLEN] = 32'hA5A5A5A5;
    slv_req_rdy = 1'b1;
    repeat (2) tick();
    mst_req_vld  = '0;
    slv_req_rdy  = 1'b0;
    slv_rsp_vld  = 1'b1;
    slv_rsp_excp = 2'b01;
    mst_rsp_rdy  = 3'b111;
    #1;
    check("t4_excp", 64'(mst_rsp_excp), 64'b01);
    check("t4_rsp_vld", 64'(mst_rsp_vld), 64'b001);
    tick();
    clear_inputs();
    #1;
    check("t4_excp_idle", 64'(mst_rsp_excp), 64'd0);

    // Reset while in RSP.
    tick();
    mst_req_vld = 3'b010;
    slv_req_rdy = 1'b1;
    repeat (2) tick();
    mst_req_vld = '0;
    slv_req_rdy = 1'b0;
    slv_rsp_vld = 1'b1;
    mst_rsp_rdy = 3'b010;
    #1;
    check("t5_pre_rsp_vld", 64'(mst_rsp_vld), 64'b010);
    check("t5_pre_busy", 64'(arb_busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_rsp_vld", 64'(mst_rsp_vld), 64'd0);
    check("t5_rst_rsp_rdy", 64'(slv_rsp_rdy), 64'd0);
    check("t5_rst_busy", 64'(arb_busy), 64'd0);
    check("t5_rst_gnt", 64'(arb_gnt), 64'd0);
    clear_inputs();
    #1;
    rst_n = 1'b1;
    m_log.delete();
    mst_req_vld = 3'b011;
    slv_req_rdy = 1'b1;
    slv_rsp_vld = 1'b1;
    mst_rsp_rdy = 3'b111;
    tick();
    check("t5_restart_gnt", 64'(arb_gnt), 64'd0);
    repeat (5) tick();
    check("t5_log_size", 64'(m_log.size()), 64'd2);

    // Pointer at 2 with masters 1 and 2 requesting.
    m_log.delete();
    mst_req_vld = 3'b110;
    tick();
    check("t6_first_gnt", 64'(arb_gnt), 64'd2);
    repeat (5) tick();
    clear_inputs();
    check("t6_count", 64'(m_log.size()), 64'd2);
    if (m_log.size() >= 2) begin
      check("t6_gnt0", 64'(m_log[0]), 64'd2);
      check("t6_gnt1", 64'(m_log[1]), 64'd1);
    end
    tick();

    // Randomized traffic, including protocol violations and stray resets.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NUM; i++) begin
        if ($urandom_range(0, 3) == 0) mst_req_vld[i] = 1'($urandom_range(0, 1));
        mst_req_read[i] = 1'($urandom_range(0, 1));
        mst_req_addr[i*ALEN +: ALEN] = ALEN'($urandom);
        mst_req_mask[i*MLEN +: MLEN] = MLEN'($urandom);
        mst_req_data[i*DLEN +: DLEN] = $urandom;
        mst_rsp_rdy[i] = ($urandom_range(0, 9) < 7);
      end
      slv_req_rdy  = ($urandom_range(0, 9) < 6);
      slv_rsp_vld  = ($urandom_range(0, 9) < 6);
      slv_rsp_excp = 2'($urandom_range(0, 3));
      slv_rsp_data = $urandom;
      if ($urandom_range(0, 299) == 0) begin
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      tick();
    end
    clear_inputs();
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
